// File: rtl/skip_seq_pkg.sv
// Shared types and constants for the skip-sequence checker.
// The checked sequence is 0,1,2,4,5,7,8,... and wraps to 0 after a configurable last value.
package skip_seq_pkg;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    typedef enum logic [1:0] {
        P0,
        P1,
        P2
    } phase_t;

    localparam int STEP_SMALL = 1;
    localparam int STEP_LARGE = 2;

    // Increment applied to an accepted sample in the given phase.
    function automatic logic [1:0] step_for(input phase_t ph);
        return (ph == P2) ? 2'(STEP_LARGE) : 2'(STEP_SMALL);
    endfunction

    // Phase after an accepted, non-wrapping sample: P0->P1->P2->P1->P2...
    function automatic phase_t phase_after(input phase_t ph);
        return (ph == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clr takes priority over inc.
// Used by skip_seq_checker for its mismatch count.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    // Count inc events, sticking at the all-ones value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/skip_seq_checker.sv
// Skip-sequence checker: hunts for a 0, then follows 0,1,2,4,5,7,8,...
// flagging mismatches (err_pulse) and accepted wrap samples (wrap_pulse).
// Optional feature macro: SKIP_SEQ_ERRCNT_EN adds the saturating err_count output.
module skip_seq_checker
    import skip_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int WRAP_VAL = 254,
    parameter int ERRCNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic [WIDTH-1:0] exp_data,
    output logic             err_pulse,
    output logic             wrap_pulse
`ifdef SKIP_SEQ_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    localparam logic [WIDTH-1:0] WRAP_W = WIDTH'(WRAP_VAL);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    state_t           state;
    phase_t           phase;
    logic             match;
    logic             is_zero;
    logic             err_event;
    logic [WIDTH-1:0] step_w;

    assign match     = (in_data == exp_data);
    assign is_zero   = (in_data == '0);
    assign step_w    = WIDTH'(step_for(phase));
    // Same condition that raises err_pulse on the next edge.
    assign err_event = in_valid && (state == LOCKED) && !match;

    // Lock/track FSM with registered expected value and one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            phase      <= P0;
            exp_data   <= '0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        // A 0 is the only legal entry point into the sequence.
                        if (is_zero) begin
                            state    <= LOCKED;
                            exp_data <= ONE_W;
                            phase    <= P1;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            if (in_data == WRAP_W) begin
                                // Wrap overrides the normal step.
                                exp_data   <= '0;
                                phase      <= P0;
                                wrap_pulse <= 1'b1;
                            end else begin
                                exp_data <= in_data + step_w;
                                phase    <= phase_after(phase);
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            if (is_zero) begin
                                // A mismatching 0 is still a valid sequence start.
                                exp_data <= ONE_W;
                                phase    <= P1;
                            end else begin
                                state    <= HUNT;
                                exp_data <= '0;
                                phase    <= P0;
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef SKIP_SEQ_ERRCNT_EN
    sat_counter #(
        .WIDTH (ERRCNT_W)
    ) u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_event),
        .clr   (1'b0),
        .count (err_count)
    );
`else
    logic unused_err_event;
    assign unused_err_event = err_event;
`endif

endmodule

// File: tb/tb_skip_seq_checker.sv
// Testbench for skip_seq_checker. Works with or without SKIP_SEQ_ERRCNT_EN.
module tb_skip_seq_checker;

    localparam int W    = 8;
    localparam int WRAP = 254;
    localparam int EW   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         locked;
    logic [W-1:0] exp_data;
    logic         err_pulse;
    logic         wrap_pulse;
`ifdef SKIP_SEQ_ERRCNT_EN
    logic [EW-1:0] err_count;
`endif

    skip_seq_checker #(
        .WIDTH    (W),
        .WRAP_VAL (WRAP),
        .ERRCNT_W (EW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .locked     (locked),
        .exp_data   (exp_data),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse)
`ifdef SKIP_SEQ_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: position in the sequence rather than phase/state registers.
    bit m_locked;
    int m_k;
    bit m_err;
    bit m_wrap;
    int m_cnt;

    // k-th value of 0,1,2,4,5,7,8,10,...
    function automatic int seqv(input int k);
        if (k < 3) return k;
        return 2 + 3 * ((k - 2) / 2) + ((((k - 2) % 2) != 0) ? 2 : 0);
    endfunction

    function automatic logic [W-1:0] m_exp();
        return W'(seqv(m_k));
    endfunction

    task automatic model_reset();
        m_locked = 0; m_k = 0; m_err = 0; m_wrap = 0; m_cnt = 0;
    endtask

    // Drive one cycle, update model at the edge, return 1 time unit after it.
    task automatic apply(input bit v, input logic [W-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        m_err  = 0;
        m_wrap = 0;
        if (v) begin
            if (!m_locked) begin
                if (d == 0) begin m_locked = 1; m_k = 1; end
            end else if (d == m_exp()) begin
                if (int'(d) == WRAP) begin m_k = 0; m_wrap = 1; end
                else m_k = m_k + 1;
            end else begin
                m_err = 1;
                if (m_cnt < (2 ** EW) - 1) m_cnt = m_cnt + 1;
                if (d == 0) m_k = 1;
                else m_locked = 0;
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1; in_valid = 0; in_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        // Held reset from time zero.
        n_vec++;
        if ({locked, err_pulse, wrap_pulse, exp_data} !== {3'b000, 8'd0}) begin
            n_miss++;
            $display("FAIL reset_init got=%b/%0d exp=000/0", {locked, err_pulse, wrap_pulse}, exp_data);
        end
        reset_dut();
        apply(1, 8'd0);
        apply(1, 8'd1);
        n_vec++;
        if (locked !== 1'b1) begin
            n_miss++; $display("FAIL reset_prelock got=%b exp=1", locked);
        end
        // Asynchronous assertion away from any clock edge.
        #2 rst = 1;
        model_reset();
        #1;
        n_vec++;
        if ({locked, err_pulse, wrap_pulse, exp_data} !== {3'b000, 8'd0}) begin
            n_miss++;
            $display("FAIL reset_async got=%b/%0d exp=000/0", {locked, err_pulse, wrap_pulse}, exp_data);
        end
`ifdef SKIP_SEQ_ERRCNT_EN
        n_vec++;
        if (err_count !== '0) begin
            n_miss++; $display("FAIL reset_errcnt got=%0d exp=0", err_count);
        end
`endif
        @(negedge clk) rst = 0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [W-1:0] seq [7] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd7, 8'd8};
        reset_dut();
        foreach (seq[i]) begin
            apply(1, seq[i]);
            n_vec++;
            if ({locked, err_pulse, wrap_pulse} !== {1'b1, 1'b0, 1'b0}) begin
                n_miss++;
                $display("FAIL basic_status[%0d] got=%b exp=100", i, {locked, err_pulse, wrap_pulse});
            end
            n_vec++;
            if (exp_data !== m_exp()) begin
                n_miss++; $display("FAIL basic_exp[%0d] got=%0d exp=%0d", i, exp_data, m_exp());
            end
            $display("basic in=%0d locked=%b exp=%0d", seq[i], locked, exp_data);
        end
        n_vec++;
        if (exp_data !== 8'd10) begin
            n_miss++; $display("FAIL basic_final got=%0d exp=10", exp_data);
        end
    endtask

    task automatic test_wrap();
        bit saw_wrap = 0;
        reset_dut();
        apply(1, 8'd0);
        for (int i = 0; i < 400 && !saw_wrap; i++) begin
            logic [W-1:0] d;
            d = m_exp();
            apply(1, d);
            n_vec++;
            if ({locked, err_pulse, wrap_pulse} !== {m_locked, m_err, m_wrap}) begin
                n_miss++;
                $display("FAIL wrap_status in=%0d got=%b exp=%b", d, {locked, err_pulse, wrap_pulse}, {m_locked, m_err, m_wrap});
            end
            n_vec++;
            if (exp_data !== m_exp()) begin
                n_miss++; $display("FAIL wrap_exp in=%0d got=%0d exp=%0d", d, exp_data, m_exp());
            end
            if (int'(d) == WRAP) begin
                saw_wrap = 1;
                n_vec++;
                if ({wrap_pulse, exp_data} !== {1'b1, 8'd0}) begin
                    n_miss++; $display("FAIL wrap_pulse got=%b/%0d exp=1/0", wrap_pulse, exp_data);
                end
                $display("wrap in=%0d wrap_pulse=%b exp=%0d", d, wrap_pulse, exp_data);
            end
        end
        n_vec++;
        if (!saw_wrap) begin
            n_miss++; $display("FAIL wrap_reached got=0 exp=1");
        end
        for (int i = 0; i < 3; i++) begin
            apply(1, W'(i));
            n_vec++;
            if ({locked, err_pulse, wrap_pulse} !== 3'b100) begin
                n_miss++; $display("FAIL wrap_resume[%0d] got=%b exp=100", i, {locked, err_pulse, wrap_pulse});
            end
        end
        n_vec++;
        if (exp_data !== 8'd4) begin
            n_miss++; $display("FAIL wrap_resume_exp got=%0d exp=4", exp_data);
        end
    endtask

    task automatic test_mismatch();
        reset_dut();
        apply(1, 8'd0); apply(1, 8'd1); apply(1, 8'd2); apply(1, 8'd4);
        apply(1, 8'd4);
        n_vec++;
        if ({locked, err_pulse, wrap_pulse} !== 3'b010) begin
            n_miss++; $display("FAIL mismatch_status got=%b exp=010", {locked, err_pulse, wrap_pulse});
        end
`ifdef SKIP_SEQ_ERRCNT_EN
        n_vec++;
        if (err_count !== 16'd1) begin
            n_miss++; $display("FAIL mismatch_errcnt got=%0d exp=1", err_count);
        end
`endif
        $display("mismatch in=4 locked=%b err=%b", locked, err_pulse);
        apply(0, 8'd0);
        n_vec++;
        if ({locked, err_pulse} !== 2'b00) begin
            n_miss++; $display("FAIL mismatch_single got=%b exp=00", {locked, err_pulse});
        end
        apply(1, 8'd0);
        n_vec++;
        if ({locked, err_pulse, exp_data} !== {2'b10, 8'd1}) begin
            n_miss++; $display("FAIL mismatch_relock got=%b/%0d exp=10/1", {locked, err_pulse}, exp_data);
        end
    endtask

    task automatic test_relock_zero();
        reset_dut();
        apply(1, 8'd0); apply(1, 8'd1); apply(1, 8'd2); apply(1, 8'd4); apply(1, 8'd5);
        apply(1, 8'd0);
        n_vec++;
        if ({locked, err_pulse, wrap_pulse, exp_data} !== {3'b110, 8'd1}) begin
            n_miss++;
            $display("FAIL relock_zero got=%b/%0d exp=110/1", {locked, err_pulse, wrap_pulse}, exp_data);
        end
        $display("relock in=0 locked=%b err=%b exp=%0d", locked, err_pulse, exp_data);
        apply(1, 8'd1);
        n_vec++;
        if ({locked, err_pulse, exp_data} !== {2'b10, 8'd2}) begin
            n_miss++; $display("FAIL relock_follow got=%b/%0d exp=10/2", {locked, err_pulse}, exp_data);
        end
    endtask

    task automatic test_idle_hold();
        reset_dut();
        apply(1, 8'd0); apply(1, 8'd1); apply(1, 8'd2); apply(1, 8'd4);
        for (int i = 0; i < 5; i++) begin
            apply(0, 8'($urandom));
            n_vec++;
            if ({locked, err_pulse, wrap_pulse, exp_data} !== {3'b100, 8'd5}) begin
                n_miss++;
                $display("FAIL idle_hold[%0d] got=%b/%0d exp=100/5", i, {locked, err_pulse, wrap_pulse}, exp_data);
            end
        end
        apply(1, 8'd5); apply(1, 8'd7);
        n_vec++;
        if ({locked, err_pulse, wrap_pulse, exp_data} !== {3'b100, 8'd8}) begin
            n_miss++;
            $display("FAIL idle_resume got=%b/%0d exp=100/8", {locked, err_pulse, wrap_pulse}, exp_data);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        apply(1, 8'd0);
        for (int i = 0; i < 200 && m_exp() != 8'd100; i++) apply(1, m_exp());
        n_vec++;
        if ({locked, exp_data} !== {1'b1, 8'd100}) begin
            n_miss++; $display("FAIL rstmid_pre got=%b/%0d exp=1/100", locked, exp_data);
        end
        #2 rst = 1;
        model_reset();
        @(negedge clk) rst = 0;
        apply(1, 8'd101);
        n_vec++;
        if ({locked, err_pulse} !== 2'b00) begin
            n_miss++; $display("FAIL rstmid_post got=%b exp=00", {locked, err_pulse});
        end
        $display("reset_mid in=101 locked=%b err=%b", locked, err_pulse);
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            int r;
            bit v;
            logic [W-1:0] d;
            r = $urandom_range(0, 9);
            v = 1;
            if (r < 6) d = m_locked ? m_exp() : 8'd0;
            else if (r < 7) d = 8'd0;
            else if (r < 8) begin v = 0; d = 8'($urandom); end
            else d = 8'($urandom);
            apply(v, d);
            n_vec++;
            if ({locked, err_pulse, wrap_pulse} !== {m_locked, m_err, m_wrap}) begin
                n_miss++;
                $display("FAIL rand_status[%0d] in=%b/%0d got=%b exp=%b", i, v, d, {locked, err_pulse, wrap_pulse}, {m_locked, m_err, m_wrap});
            end
            if (m_locked) begin
                n_vec++;
                if (exp_data !== m_exp()) begin
                    n_miss++; $display("FAIL rand_exp[%0d] got=%0d exp=%0d", i, exp_data, m_exp());
                end
            end
`ifdef SKIP_SEQ_ERRCNT_EN
            n_vec++;
            if (int'(err_count) !== m_cnt) begin
                n_miss++; $display("FAIL rand_errcnt[%0d] got=%0d exp=%0d", i, err_count, m_cnt);
            end
`endif
        end
        $display("random done, model errors=%0d", m_cnt);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = '0;
        model_reset();
        #3;
        test_reset();
        test_basic();
        test_wrap();
        test_mismatch();
        test_relock_zero();
        test_idle_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
